// File: rtl/uart_dmi_stream_codec.sv
// uart_dmi_stream_codec: UART byte-stream escape codec with RX FWFT FIFO and TX escape encoder.
// Optional ESC follower timeout enabled by defining UART_DMI_CODEC_ESC_TIMEOUT_EN.
module uart_dmi_stream_codec #(
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] ESC_BYTE    = 8'h1B,
    parameter int         ESC_TIMEOUT = 1024
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       RX_VALID_I,
    input  logic [7:0] RX_DATA_I,
    input  logic       READ_I,
    output logic [7:0] DATA_REC_O,
    output logic       CMD_REC_O,
    output logic       RX_EMPTY_O,
    output logic       RX_OVERFLOW_O,
    input  logic       WRITE_I,
    input  logic [7:0] DATA_SEND_I,
    input  logic       SEND_COMMAND_I,
    input  logic [7:0] COMMAND_I,
    output logic       TX_READY_O,
    output logic       TX_VALID_O,
    output logic [7:0] TX_DATA_O,
    input  logic       TX_READY_I,
    output logic       ESC_ERROR_O
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {D_IDLE, D_ESC} d_state_t;
    typedef enum logic [1:0] {T_IDLE, T_FIRST, T_SECOND} t_state_t;

    d_state_t      d_state, d_next;
    logic          push, push_cmd, do_push, do_pop, rx_full, esc_to;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [8:0]    mem [FIFO_DEPTH];

`ifdef UART_DMI_CODEC_ESC_TIMEOUT_EN
    localparam int TW = $clog2(ESC_TIMEOUT) + 1;
    logic [TW-1:0] esc_cnt;
    logic          esc_err;
    assign esc_to      = d_state == D_ESC && !RX_VALID_I && esc_cnt == TW'(ESC_TIMEOUT - 1);
    assign ESC_ERROR_O = esc_err;
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            esc_cnt <= '0;
            esc_err <= 1'b0;
        end else begin
            esc_cnt <= (RX_VALID_I || d_state != D_ESC) ? '0 : esc_cnt + TW'(1);
            esc_err <= esc_to;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^ESC_TIMEOUT;
    assign esc_to         = 1'b0;
    assign ESC_ERROR_O    = 1'b0;
`endif

    // A second ESC collapses to a literal ESC data byte; any other follower is a command.
    always_comb begin
        d_next   = d_state;
        push     = 1'b0;
        push_cmd = 1'b0;
        if (RX_VALID_I) begin
            d_next   = (d_state == D_IDLE && RX_DATA_I == ESC_BYTE) ? D_ESC : D_IDLE;
            push     = d_state == D_ESC || RX_DATA_I != ESC_BYTE;
            push_cmd = d_state == D_ESC && RX_DATA_I != ESC_BYTE;
        end else if (esc_to) begin
            d_next = D_IDLE;
        end
    end

    assign RX_EMPTY_O              = count == '0;
    assign rx_full                 = count == (AW+1)'(FIFO_DEPTH);
    assign do_pop                  = READ_I && !RX_EMPTY_O;
    assign do_push                 = push && (!rx_full || do_pop);
    assign {CMD_REC_O, DATA_REC_O} = RX_EMPTY_O ? 9'd0 : mem[rd_ptr];

    always_ff @(posedge CLK_I) begin
        if (do_push) mem[wr_ptr] <= {push_cmd, RX_DATA_I};
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            d_state       <= D_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            RX_OVERFLOW_O <= 1'b0;
        end else begin
            d_state       <= d_next;
            wr_ptr        <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr        <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count         <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            RX_OVERFLOW_O <= push && !do_push;
        end
    end

    t_state_t   t_state, t_next;
    logic       cmd_pend, has_sec, ld_has;
    logic [7:0] cmd_byte, sec_data, ld_data, ld_sec;

    assign TX_READY_O = t_state == T_IDLE && !cmd_pend && !SEND_COMMAND_I;
    assign TX_VALID_O = t_state != T_IDLE;

    // A strobe in the current cycle is taken directly so the first byte appears next cycle.
    always_comb begin
        t_next  = t_state;
        ld_data = TX_DATA_O;
        ld_sec  = sec_data;
        ld_has  = has_sec;
        case (t_state)
            T_IDLE: begin
                if (cmd_pend || SEND_COMMAND_I) begin
                    t_next  = T_FIRST;
                    ld_data = ESC_BYTE;
                    ld_sec  = SEND_COMMAND_I ? COMMAND_I : cmd_byte;
                    ld_has  = 1'b1;
                end else if (WRITE_I) begin
                    t_next  = T_FIRST;
                    ld_data = DATA_SEND_I;
                    ld_sec  = ESC_BYTE;
                    ld_has  = DATA_SEND_I == ESC_BYTE;
                end
            end
            T_FIRST: begin
                if (TX_READY_I) begin
                    t_next  = has_sec ? T_SECOND : T_IDLE;
                    ld_data = has_sec ? sec_data : TX_DATA_O;
                end
            end
            T_SECOND: t_next = TX_READY_I ? T_IDLE : T_SECOND;
            default:  t_next = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            t_state   <= T_IDLE;
            TX_DATA_O <= 8'd0;
            sec_data  <= 8'd0;
            has_sec   <= 1'b0;
            cmd_pend  <= 1'b0;
            cmd_byte  <= 8'd0;
        end else begin
            t_state   <= t_next;
            TX_DATA_O <= ld_data;
            sec_data  <= ld_sec;
            has_sec   <= ld_has;
            cmd_pend  <= t_state != T_IDLE && (cmd_pend || SEND_COMMAND_I);
            cmd_byte  <= SEND_COMMAND_I ? COMMAND_I : cmd_byte;
        end
    end
endmodule
